// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// All segment patterns are active-low: a 0 bit lights the segment.
// Bit order is {a,b,c,d,e,f,g}, i.e. seg[6]=a ... seg[0]=g.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Phase within a digit slot: blanking gap first, then the lit digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load port of the scan controller: a valid/ready handshake carrying one
// full set of BCD digits plus decimal-point requests.
//   load_valid  producer offers a new digit set
//   load_ready  consumer's pending buffer is empty
//   load_data   4 bits per digit, nibble i drives digit i
//   load_dp     one decimal-point request per digit, 1 = lit
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
) ();

  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;
  logic [DIGITS-1:0]     load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
//   i_val  4-bit digit value; 10..15 decode to all segments off
//   o_seg  {a,b,c,d,e,f,g}, 0 = segment lit
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Each digit owns a slot of SLOT_CYC clocks: BLANK_CYC clocks with every
// anode off (anti-ghosting gap), then the digit is lit for the remainder.
// New digit sets arrive on a valid/ready port into a pending buffer and are
// copied to the active buffer only at the end of a full frame, so a frame
// never mixes old and new digits.
//   clk_50mhz   system clock
//   rst_n       asynchronous active-low reset
//   ld          load port (slave side)
//   seg         segments a..g, active-low
//   dp          decimal point, active-low
//   an          digit enables, active-low, at most one low
//   frame_tick  one-cycle pulse the cycle after a pending set is committed
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_HZ   = 1000,
  parameter int DIGITS    = 4,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  seg_scan_ctrl_if.slave    ld,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              frame_tick
);

  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = $clog2(SLOT_CYC);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*DIGITS-1:0]   r_active;
  logic [DIGITS-1:0]     r_active_dp;
  logic [4*DIGITS-1:0]   r_pend;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_flag;
  logic                  r_ready;
  logic                  r_frame_tick;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_an;

  logic                  w_cnt_last;
  logic                  w_idx_last;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  scan_state_t           w_state_nxt;
  logic                  w_show_nxt;
  logic                  w_commit;
  logic                  w_accept;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic [DIGITS-1:0]     w_an;
  logic [6:0]            w_dec_seg;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_idx_last = (r_idx == IDX_LAST);
  assign w_cnt_nxt  = w_cnt_last ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt  = !w_cnt_last ? r_idx : (w_idx_last ? '0 : r_idx + 1'b1);

  // Commit only on the final SHOW cycle of the last digit. A load can be
  // accepted only while the flag is clear, so commit and accept are
  // mutually exclusive and a capture on this cycle waits a full frame.
  assign w_commit = (r_state == ST_SHOW) && w_cnt_last && w_idx_last && r_pend_flag;
  assign w_accept = ld.load_valid && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_cnt_last)          w_state_nxt = ST_BLANK;
      default:                           w_state_nxt = ST_BLANK;
    endcase
  end

  assign w_show_nxt = (w_state_nxt == ST_SHOW);

  // Outputs are registered from next-cycle position so that seg/an/dp line
  // up with the counter; the mux selects the digit that will be shown.
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_an     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib    = r_active[4*i +: 4];
        w_dp_sel = r_active_dp[i];
        w_an[i]  = !w_show_nxt;
      end
    end
  end

  seg7_decode u_dec (
    .i_val (w_nib),
    .o_seg (w_dec_seg)
  );

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_active_dp  <= '0;
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_flag  <= 1'b0;
      r_ready      <= 1'b1;
      r_frame_tick <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_an         <= '1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_an         <= w_an;
      r_seg        <= w_show_nxt ? w_dec_seg : SEG_BLANK;
      r_dp         <= w_show_nxt ? ~w_dp_sel : 1'b1;
      r_frame_tick <= w_commit;
      if (w_commit) begin
        r_active    <= r_pend;
        r_active_dp <= r_pend_dp;
        r_pend_flag <= 1'b0;
        r_ready     <= 1'b1;
      end else if (w_accept) begin
        r_pend      <= ld.load_data;
        r_pend_dp   <= ld.load_dp;
        r_pend_flag <= 1'b1;
        r_ready     <= 1'b0;
      end
    end
  end

  assign seg           = r_seg;
  assign dp            = r_dp;
  assign an            = r_an;
  assign frame_tick    = r_frame_tick;
  assign ld.load_ready = r_ready;

endmodule
